// File: rtl/bv_match_if.sv
// Segment stream in from the bit-vector AND stage and the match result out
// to the action-lookup stage.
interface bv_match_if #(
    parameter int SEG_W = 36,
    parameter int IDX_W = 9
);
    logic             bv_in_valid;
    logic             bv_in_first;
    logic [SEG_W-1:0] bv_in;
    logic             match_valid;
    logic             match_hit;
    logic [IDX_W-1:0] match_index;
    logic             seq_err;

    modport slave (
        input  bv_in_valid,
        input  bv_in_first,
        input  bv_in,
        output match_valid,
        output match_hit,
        output match_index,
        output seq_err
    );

    modport master (
        output bv_in_valid,
        output bv_in_first,
        output bv_in,
        input  match_valid,
        input  match_hit,
        input  match_index,
        input  seq_err
    );
endinterface

// File: rtl/bv_match_encoder.sv
// Resolves the lowest-numbered matching rule from a stream of SEG_NUM
// bit-vector segments and emits one hit/index result per lookup.
module bv_match_encoder #(
    parameter int SEG_W   = 36,
    parameter int SEG_NUM = 8,
    parameter int IDX_W   = 9
) (
    input  logic         clk,
    input  logic         reset,
    bv_match_if.slave    bus
);
    localparam int POS_W = $clog2(SEG_W);
    localparam int CNT_W = $clog2(SEG_NUM);

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_any;
    logic [POS_W-1:0] r_s1_pos;
    logic [POS_W-1:0] w_pos;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_seg_cnt;
    logic [CNT_W-1:0] w_seg_cnt_next;
    logic             r_found;
    logic             w_found_next;
    logic [IDX_W-1:0] r_acc_idx;
    logic [IDX_W-1:0] w_acc_idx_next;

    logic             r_match_valid;
    logic             w_match_valid_next;
    logic             r_match_hit;
    logic             w_match_hit_next;
    logic [IDX_W-1:0] r_match_index;
    logic [IDX_W-1:0] w_match_index_next;
    logic             r_seq_err;
    logic             w_seq_err_next;

    logic [IDX_W-1:0] w_cand_idx;
    logic             w_fin_found;
    logic [IDX_W-1:0] w_fin_idx;

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        w_pos = '0;
        for (int i = SEG_W - 1; i >= 0; i--) begin
            if (bus.bv_in[i]) begin
                w_pos = POS_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_any   <= 1'b0;
            r_s1_pos   <= '0;
        end else begin
            r_s1_valid <= bus.bv_in_valid;
            if (bus.bv_in_valid) begin
                r_s1_first <= bus.bv_in_first;
                r_s1_any   <= |bus.bv_in;
                r_s1_pos   <= w_pos;
            end
        end
    end

    assign w_cand_idx  = IDX_W'(r_seg_cnt) * IDX_W'(SEG_W) + IDX_W'(r_s1_pos);
    assign w_fin_found = r_found | r_s1_any;
    assign w_fin_idx   = r_found ? r_acc_idx : (r_s1_any ? w_cand_idx : '0);

    always_comb begin
        w_state_next       = r_state;
        w_seg_cnt_next     = r_seg_cnt;
        w_found_next       = r_found;
        w_acc_idx_next     = r_acc_idx;
        w_match_valid_next = 1'b0;
        w_match_hit_next   = r_match_hit;
        w_match_index_next = r_match_index;
        w_seq_err_next     = 1'b0;

        if (r_s1_valid) begin
            if (r_s1_first) begin
                // A first segment always opens a new lookup; in ACCUM the partial one is dropped.
                w_seq_err_next = (r_state == ST_ACCUM);
                w_found_next   = r_s1_any;
                w_acc_idx_next = r_s1_any ? IDX_W'(r_s1_pos) : '0;
                w_seg_cnt_next = CNT_W'(1);
                w_state_next   = ST_ACCUM;
            end else if (r_state == ST_IDLE) begin
                w_seq_err_next = 1'b1;
            end else begin
                w_found_next   = w_fin_found;
                w_acc_idx_next = w_fin_idx;
                if (r_seg_cnt == CNT_W'(SEG_NUM - 1)) begin
                    w_match_valid_next = 1'b1;
                    w_match_hit_next   = w_fin_found;
                    w_match_index_next = w_fin_idx;
                    w_seg_cnt_next     = '0;
                    w_found_next       = 1'b0;
                    w_acc_idx_next     = '0;
                    w_state_next       = ST_IDLE;
                end else begin
                    w_seg_cnt_next = r_seg_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_seg_cnt     <= '0;
            r_found       <= 1'b0;
            r_acc_idx     <= '0;
            r_match_valid <= 1'b0;
            r_match_hit   <= 1'b0;
            r_match_index <= '0;
            r_seq_err     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_seg_cnt     <= w_seg_cnt_next;
            r_found       <= w_found_next;
            r_acc_idx     <= w_acc_idx_next;
            r_match_valid <= w_match_valid_next;
            r_match_hit   <= w_match_hit_next;
            r_match_index <= w_match_index_next;
            r_seq_err     <= w_seq_err_next;
        end
    end

    assign bus.match_valid = r_match_valid;
    assign bus.match_hit   = r_match_hit;
    assign bus.match_index = r_match_index;
    assign bus.seq_err     = r_seq_err;

endmodule

// File: tb/tb_bv_match_encoder.sv
// Scoreboard bench for bv_match_encoder: expected results and error pulses
// are queued with their due cycle, a monitor pops and compares them.
module tb_bv_match_encoder;
    localparam int SEG_W   = 36;
    localparam int SEG_NUM = 8;
    localparam int IDX_W   = 9;
    localparam int NBITS   = SEG_W * SEG_NUM;

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    exp_t exp_q[$];
    int   err_q[$];

    bv_match_if #(.SEG_W(SEG_W), .IDX_W(IDX_W)) ifc ();

    bv_match_encoder #(.SEG_W(SEG_W), .SEG_NUM(SEG_NUM), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: lowest set bit across the whole flattened rule vector.
    function automatic logic [IDX_W:0] ref_model(input logic [NBITS-1:0] v);
        for (int i = 0; i < NBITS; i++) begin
            if (v[i]) return {1'b1, IDX_W'(i)};
        end
        return '0;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (ifc.match_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result cyc=%0d got hit=%0d idx=%0d, required no result",
                         cyc, ifc.match_hit, ifc.match_index);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ifc.match_hit !== e.hit || ifc.match_index !== e.idx || cyc != e.due) begin
                    errors++;
                    $display("FAIL result cyc=%0d got hit=%0d idx=%0d, required hit=%0d idx=%0d at cyc=%0d",
                             cyc, ifc.match_hit, ifc.match_index, e.hit, e.idx, e.due);
                end else begin
                    $display("result cyc=%0d hit=%0d idx=%0d ok", cyc, ifc.match_hit, ifc.match_index);
                end
            end
        end
        if (ifc.seq_err) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_seq_err cyc=%0d got seq_err=1, required 0", cyc);
            end else begin
                int d;
                d = err_q.pop_front();
                if (cyc != d) begin
                    errors++;
                    $display("FAIL seq_err_timing got cyc=%0d, required cyc=%0d", cyc, d);
                end else begin
                    $display("seq_err cyc=%0d ok", cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic f, input logic [SEG_W-1:0] d);
        @(posedge clk);
        #1;
        ifc.bv_in_valid = v;
        ifc.bv_in_first = f;
        ifc.bv_in       = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic send_lookup(input logic [NBITS-1:0] v, input int max_gap,
                               input logic restart, input logic e_hit,
                               input logic [IDX_W-1:0] e_idx);
        exp_t e;
        for (int s = 0; s < SEG_NUM; s++) begin
            drive(1'b1, (s == 0), v[s*SEG_W +: SEG_W]);
            if (s == 0 && restart) err_q.push_back(cyc + 2);
            if (s == SEG_NUM - 1) begin
                e.hit = e_hit;
                e.idx = e_idx;
                e.due = cyc + 2;
                exp_q.push_back(e);
            end else if (max_gap > 0) begin
                idle($urandom_range(0, max_gap));
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_match_valid"}, int'(ifc.match_valid), 0);
        check_val({tag, "_match_hit"},   int'(ifc.match_hit), 0);
        check_val({tag, "_match_index"}, int'(ifc.match_index), 0);
        check_val({tag, "_seq_err"},     int'(ifc.seq_err), 0);
    endtask

    logic [NBITS-1:0] v_single, v_prio, v_zero, v_last, v_tmp;
    logic [IDX_W:0]   r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifc.bv_in_valid = 1'b0;
        ifc.bv_in_first = 1'b0;
        ifc.bv_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(2);

        v_single = '0; v_single[2*36+5] = 1'b1;
        v_prio   = '0; v_prio[36] = 1'b1; v_prio[46] = 1'b1; v_prio[4*36+3] = 1'b1;
        v_zero   = '0;
        v_last   = '0; v_last[287] = 1'b1;

        send_lookup(v_single, 0, 1'b0, 1'b1, 9'd77);
        idle(4);
        send_lookup(v_prio, 0, 1'b0, 1'b1, 9'd36);
        idle(3);
        send_lookup(v_zero, 0, 1'b0, 1'b0, 9'd0);
        idle(3);

        // Back-to-back, then the same three with gaps.
        send_lookup(v_single, 0, 1'b0, 1'b1, 9'd77);
        send_lookup(v_prio,   0, 1'b0, 1'b1, 9'd36);
        send_lookup(v_last,   0, 1'b0, 1'b1, 9'd287);
        idle(3);
        send_lookup(v_single, 3, 1'b0, 1'b1, 9'd77);
        send_lookup(v_prio,   3, 1'b0, 1'b1, 9'd36);
        send_lookup(v_last,   3, 1'b0, 1'b1, 9'd287);
        idle(3);

        // Aborted partial lookup (with an early hit) followed by a restart.
        drive(1'b1, 1'b1, 36'h1);
        drive(1'b1, 1'b0, 36'h0);
        drive(1'b1, 1'b0, 36'h0);
        v_tmp = '0; v_tmp[100] = 1'b1; v_tmp[200] = 1'b1;
        send_lookup(v_tmp, 0, 1'b1, 1'b1, 9'd100);
        idle(3);
        // Orphan segment while idle.
        drive(1'b1, 1'b0, 36'hFFF);
        err_q.push_back(cyc + 2);
        idle(4);

        // Reset mid-lookup, outputs previously holding a hit.
        send_lookup(v_last, 0, 1'b0, 1'b1, 9'd287);
        idle(3);
        for (int s = 0; s < 4; s++) drive(1'b1, (s == 0), 36'h1);
        @(posedge clk);
        #1;
        ifc.bv_in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs_zero("after_reset");
        idle(3);
        v_tmp = '0; v_tmp[0] = 1'b1;
        send_lookup(v_tmp, 0, 1'b0, 1'b1, 9'd0);
        idle(3);

        // Randomized lookups against the reference model.
        for (int n = 0; n < 4000; n++) begin
            int mode;
            int cut;
            mode = $urandom_range(0, 9);
            v_tmp = '0;
            if (mode == 1 || mode == 2 || mode == 3) begin
                v_tmp[$urandom_range(0, NBITS - 1)] = 1'b1;
            end else if (mode != 0) begin
                for (int w = 0; w < NBITS / 32; w++) v_tmp[w*32 +: 32] = $urandom();
                cut = $urandom_range(0, NBITS - 1);
                for (int i = 0; i < cut; i++) v_tmp[i] = 1'b0;
            end
            r = ref_model(v_tmp);
            send_lookup(v_tmp, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, r[IDX_W], r[IDX_W-1:0]);
        end

        idle(10);
        check_val("results_outstanding", exp_q.size(), 0);
        check_val("seq_err_outstanding", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
